// File: rtl/exu_pkg.sv
// -----------------------------------------------------------------------------
// exu_pkg
// Shared definitions for the execute unit: operation codes in the
// {funct7[5], funct3} encoding, the I-type immediate width and the
// control FSM state encoding.
// -----------------------------------------------------------------------------
package exu_pkg;

    localparam int IMM_W = 12;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } exu_state_e;

endpackage

// File: rtl/exu_mul_iter.sv
// -----------------------------------------------------------------------------
// exu_mul_iter
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// One multiplier bit is consumed per clock. `start` loads the operands;
// `done` is asserted combinationally during the final iteration cycle and
// `product` then already carries the finished value, so the caller can
// capture it on the same edge that completes the last iteration.
// Only elaborated when EXU_MUL_EN is defined.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load a/b and begin iterating
//   a, b            multiplicand, multiplier (XLEN)
//   done            final iteration in progress
//   product         running sum including the current iteration (XLEN)
// -----------------------------------------------------------------------------
module exu_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  acc_next;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CNT_W'(XLEN - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exu_alu.sv
// -----------------------------------------------------------------------------
// exu_alu
// Registered, handshaked RV32I/RV64I integer execute unit between decode and
// writeback. Operand B is either src2 or the sign-extended I-type immediate.
// Single-cycle ops complete with latency 1; results are held while the
// downstream stalls, and a new op can be accepted in the same cycle the old
// result retires (one result per cycle sustained).
//
// Optional feature macro: EXU_MUL_EN
//   defined   -> op 1001 is MUL, executed by exu_mul_iter over XLEN cycles
//   undefined -> op 1001 is treated as an unknown op (single cycle, result 0)
//
// Parameters: XLEN (32 or 64), TAGW (destination tag width)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_op                      {funct7[5], funct3} op code
//   in_src1, in_src2           operands (XLEN)
//   in_imm, in_use_imm         12-bit I-type immediate and select
//   in_rd                      destination tag
//   out_valid / out_ready      downstream handshake
//   out_result, out_rd         registered result and its tag
// -----------------------------------------------------------------------------
module exu_alu
    import exu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [IMM_W-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [TAGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_rd
);

    localparam int SHW = $clog2(XLEN);

    exu_state_e             state_q;
    exu_state_e             state_d;
    logic                   accept;
    logic                   is_mul;
    logic [XLEN-1:0]        opb;
    logic signed [XLEN-1:0] src1_s;
    logic signed [XLEN-1:0] opb_s;
    logic [SHW-1:0]         shamt;
    logic [XLEN-1:0]        alu_res;
    logic [XLEN-1:0]        result_p1;
    logic [TAGW-1:0]        rd_p1;

    // rst_n gates in_ready so nothing is accepted while reset is held.
    assign in_ready = rst_n && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // ---- stage p0: operand select and ALU (combinational) ----
    assign opb    = in_use_imm ? {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm} : in_src2;
    assign src1_s = in_src1;
    assign opb_s  = opb;
    assign shamt  = opb[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = in_src1 + opb;
            // There is no SUBI in the ISA, so the immediate form adds.
            OP_SUB:  alu_res = in_use_imm ? (in_src1 + opb) : (in_src1 - opb);
            OP_SLL:  alu_res = in_src1 << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (src1_s < opb_s)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_src1 < opb)};
            OP_XOR:  alu_res = in_src1 ^ opb;
            OP_SRL:  alu_res = in_src1 >> shamt;
            OP_SRA:  alu_res = $unsigned(src1_s >>> shamt);
            OP_OR:   alu_res = in_src1 | opb;
            OP_AND:  alu_res = in_src1 & opb;
`ifndef EXU_MUL_EN
            OP_MUL:  alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef EXU_MUL_EN
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign is_mul = (in_op == OP_MUL);

    exu_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (in_src1),
        .b       (opb),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    // ---- control FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? ST_BUSY : ST_DONE;
                end
            end
`ifdef EXU_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = is_mul ? ST_BUSY : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- stage p1: registered result ----
    // Accepts only happen in IDLE or retiring DONE, so they never collide
    // with the multiplier completing in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
            rd_p1     <= '0;
        end else begin
            if (accept) begin
                rd_p1 <= in_rd;
                if (!is_mul) begin
                    result_p1 <= alu_res;
                end
            end
`ifdef EXU_MUL_EN
            if ((state_q == ST_BUSY) && mul_done) begin
                result_p1 <= mul_product;
            end
`endif
        end
    end

    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_p1;
    assign out_rd     = rd_p1;

endmodule

// File: doc/exu_alu.md
# exu_alu

Registered, handshaked execute unit that replaces the single-purpose combinational `exu` (ADDI-only, zero-extended immediate). It implements the RV32I/RV64I integer ALU operations with a parameterised data width, sign-extends I-type immediates, and optionally adds an iterative multi-cycle multiplier. It sits between the decode stage (IDU) and the writeback stage (WBU), with valid/ready handshakes on both sides.

## Interface
- `XLEN`, 32: datapath width; must be 32 or 64.
- `TAGW`, 5: width of the destination-register tag carried through the unit.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has an operation.
- `in_ready`  out  1  unit can accept an operation this cycle.
- `in_op`  in  4  operation code, `{funct7[5], funct3}` encoding (see Operation).
- `in_src1`  in  XLEN  operand A.
- `in_src2`  in  XLEN  operand B when `in_use_imm`=0.
- `in_imm`  in  12  I-type immediate.
- `in_use_imm`  in  1  1: operand B = sign-extended `in_imm`.
- `in_rd`  in  TAGW  destination tag.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  downstream consumes the result.
- `out_result`  out  XLEN  result.
- `out_rd`  out  TAGW  tag of the result.

## Operation
- Op codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100.
  - SRL 0101, SRA 1101, OR 0110, AND 0111, MUL 1001 (MUL only with the macro).
- Any other code completes as a single-cycle op with result 0.
- Operand B = `in_use_imm` ? `{{(XLEN-12){in_imm[11]}}, in_imm}` : `in_src2`.
- SUB with `in_use_imm`=1 executes as ADD.
- Shift amount is `B[$clog2(XLEN)-1:0]`; higher bits are ignored.
- SLT is a signed compare and SLTU an unsigned compare; both return 0 or 1 zero-extended.
- MUL returns the low XLEN bits of A*B, which is sign-agnostic.
- All arithmetic wraps modulo 2^XLEN; no overflow flag.
- FSM states:
  - IDLE: `out_valid`=0.
  - BUSY: MUL iterating.
  - DONE: `out_valid`=1.
- FSM transitions:
  - IDLE→DONE on handshake of a non-MUL op.
  - IDLE→BUSY on handshake of MUL.
  - BUSY→DONE after XLEN iterations.
  - DONE→IDLE on `out_ready` with no new handshake.
  - DONE→DONE or DONE→BUSY on `out_ready` together with a new handshake.
- `in_ready` = `rst_n` && (state==IDLE || (state==DONE && `out_ready`)).
  - Combinational from `out_ready`, so back-to-back ops sustain one result per cycle.
- `out_result`/`out_rd` are registered and held stable while `out_valid` && !`out_ready`.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `out_valid`=0, `out_result`=0, `out_rd`=0, iteration counter=0, partial product=0.
  - `in_ready`=0 while `rst_n` is low, and 1 in the first cycle after release.
- Non-MUL op accepted at edge N: `out_valid`=1 after edge N, i.e. latency 1.
- MUL op accepted at edge N:
  - One multiplier bit is processed per cycle.
  - `out_valid` rises after edge N+XLEN, i.e. latency XLEN (32 for XLEN=32).
  - `in_ready`=0 throughout BUSY.
- Reset asserted mid-MUL: the operation is discarded and no result is produced.
- `in_valid` while `in_ready`=0: ignored; upstream holds its inputs.
- A handshake on the same cycle as `out_ready` in DONE:
  - The old result retires.
  - The new result appears on the next edge, with no bubble.

## Configuration
- `EXU_MUL_EN` defined:
  - Code 1001 is MUL with BUSY state, counter and `exu_mul_iter` instance.
- `EXU_MUL_EN` undefined:
  - The BUSY state and the multiplier are not instantiated.
  - Code 1001 behaves as an unknown op: single cycle, result 0.

## Structure
- Shared package `exu_pkg`: op-code localparams, FSM state encoding, immediate width (12).
- One natural sub-module, `exu_mul_iter`:
  - Shift-add multiplier with start/done and an XLEN-cycle counter.
  - Only elaborated under `EXU_MUL_EN`.
- The ALU result mux stays in the top level.

## Test plan
- ADDI with negative immediate: src1=5, imm=12'hFFF, use_imm=1, op ADD → result 0x00000004 one cycle after accept; rd tag 3 in, 3 out.
- SRA vs SRL: src1=0x80000000, src2=4 → SRA 0xF8000000, SRL 0x08000000.
- SLT vs SLTU: src1=0xFFFFFFFF, src2=1 → SLT 1, SLTU 0.
- Backpressure:
  - ADD 1+2 with `out_ready` held low for 3 cycles → result 3 stable and `in_ready`=0.
  - Raise `out_ready` together with a new XOR 0xF0^0xFF → 3 retires, then 0x0F on the next cycle.
- MUL (macro on): 7 × 0xFFFFFFFD → 0xFFFFFFEB, `out_valid` 32 cycles after accept, `in_ready` low throughout.
- Reset mid-MUL: assert `rst_n` low at BUSY cycle 10 → `out_valid`=0 immediately; after release, ADD 2+2 → 4 with latency 1.
